// File: rtl/avr_io_capture.sv
//==============================================================================
//  Module      : avr_io_capture
//  Description : Input-capture peripheral on the AVR I/O bus. It timestamps
//                selected edges of an asynchronous pin using a prescaled
//                16-bit interval counter. Each interval is latched into a
//                capture register and can raise an interrupt. Software reads
//                the 16-bit result atomically through a low-byte-first
//                temporary latch.
//
//  Ports       : clk     - system clock, rising edge
//                rst     - asynchronous active-high reset
//                io_re   - I/O read strobe (read wins over a coincident write)
//                io_we   - I/O write strobe
//                io_a    - register select: 0 CAPL, 1 TMP, 2 CCR, 3 CSR
//                io_do   - read data, 0 whenever io_re is low
//                io_di   - write data
//                cap_in  - asynchronous external capture pin
//                irq     - level interrupt request
//
//  Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module avr_io_capture (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [1:0] io_a,
    output logic [7:0] io_do,
    input  logic [7:0] io_di,
    input  logic       cap_in,
    output logic       irq
);

    //--------------------------------------------------------------------------
    // Register map and field encodings
    //--------------------------------------------------------------------------
    localparam logic [1:0] C_A_CAPL = 2'd0;
    localparam logic [1:0] C_A_TMP  = 2'd1;
    localparam logic [1:0] C_A_CCR  = 2'd2;
    localparam logic [1:0] C_A_CSR  = 2'd3;

    localparam logic [1:0] C_PS_1    = 2'b00;
    localparam logic [1:0] C_PS_16   = 2'b01;
    localparam logic [1:0] C_PS_256  = 2'b10;
    localparam logic [1:0] C_PS_4096 = 2'b11;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [11:0] r_pre;
    logic [15:0] r_tcnt;
    logic [15:0] r_cap;
    logic [7:0]  r_tmp;
    logic        r_cie;
    logic        r_oie;
    logic [1:0]  r_esel;
    logic [1:0]  r_psel;
    logic        r_capf;
    logic        r_ovf;
    logic        r_miss;

    //--------------------------------------------------------------------------
    // Bus decode. A read in the same cycle as a write suppresses the write.
    //--------------------------------------------------------------------------
    logic w_wr_en;
    logic w_ccr_wr;
    logic w_csr_wr;
    logic w_tmp_wr;
    logic w_capl_rd;

    assign w_wr_en   = io_we & ~io_re;
    assign w_ccr_wr  = w_wr_en & (io_a == C_A_CCR);
    assign w_csr_wr  = w_wr_en & (io_a == C_A_CSR);
    assign w_tmp_wr  = w_wr_en & (io_a == C_A_TMP);
    assign w_capl_rd = io_re   & (io_a == C_A_CAPL);

    //--------------------------------------------------------------------------
    // Pin synchronizer and edge detection
    //--------------------------------------------------------------------------
    logic w_rise;
    logic w_fall;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= cap_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    //--------------------------------------------------------------------------
    // Event qualification. The edge select in effect is the registered CCR
    // value, so a CCR write only changes qualification from the next cycle.
    //--------------------------------------------------------------------------
    logic w_cap_ev;
    logic w_tick;
    logic w_ovf_ev;

    assign w_cap_ev = (w_rise & r_esel[0]) | (w_fall & r_esel[1]);

    // Prescaler bit N falls on the increment where bits N..0 are all ones,
    // so the tick is flagged in the cycle ending at that edge.
    always_comb begin
        w_tick = 1'b0;
        case (r_psel)
            C_PS_1:    w_tick = 1'b1;
            C_PS_16:   w_tick = &r_pre[3:0];
            C_PS_256:  w_tick = &r_pre[7:0];
            C_PS_4096: w_tick = &r_pre[11:0];
            default:   w_tick = 1'b0;
        endcase
    end

    // A capture in the wrap cycle takes priority and suppresses the overflow.
    assign w_ovf_ev = w_tick & (&r_tcnt) & ~w_cap_ev;

    //--------------------------------------------------------------------------
    // Control register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cie  <= 1'b0;
            r_oie  <= 1'b0;
            r_esel <= 2'b00;
            r_psel <= 2'b00;
        end else if (w_ccr_wr) begin
            r_cie  <= io_di[7];
            r_oie  <= io_di[6];
            r_esel <= io_di[3:2];
            r_psel <= io_di[1:0];
        end
    end

    //--------------------------------------------------------------------------
    // Prescaler and interval counter. A CCR write restarts both so that the
    // first interval after reconfiguration is measured from a known phase.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= 12'd0;
        end else if (w_ccr_wr) begin
            r_pre <= 12'd0;
        end else begin
            r_pre <= r_pre + 12'd1;
        end
    end

    // Natural 16-bit wrap from 0xFFFF to 0 covers the overflow case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= 16'd0;
        end else if (w_cap_ev || w_ccr_wr) begin
            r_tcnt <= 16'd0;
        end else if (w_tick) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    //--------------------------------------------------------------------------
    // Capture register and temporary high-byte latch. A CAPL read in the
    // capture cycle latches the pre-update high byte, keeping the pair
    // coherent with the low byte returned on the bus.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= 16'd0;
        end else if (w_cap_ev) begin
            r_cap <= r_tcnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmp <= 8'd0;
        end else if (w_capl_rd) begin
            r_tmp <= r_cap[15:8];
        end else if (w_tmp_wr) begin
            r_tmp <= io_di;
        end
    end

    //--------------------------------------------------------------------------
    // Status flags: write-one-to-clear, hardware set wins over the clear.
    //--------------------------------------------------------------------------
    logic w_clr_capf;
    logic w_clr_ovf;
    logic w_clr_miss;
    logic w_miss_ev;

    assign w_clr_capf = w_csr_wr & io_di[7];
    assign w_clr_ovf  = w_csr_wr & io_di[6];
    assign w_clr_miss = w_csr_wr & io_di[5];

    // A capture only counts as missed if software had not already
    // acknowledged the previous one in this same cycle.
    assign w_miss_ev  = w_cap_ev & r_capf & ~w_clr_capf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capf <= 1'b0;
            r_ovf  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            if (w_cap_ev) begin
                r_capf <= 1'b1;
            end else if (w_clr_capf) begin
                r_capf <= 1'b0;
            end

            if (w_ovf_ev) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end

            if (w_miss_ev) begin
                r_miss <= 1'b1;
            end else if (w_clr_miss) begin
                r_miss <= 1'b0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Read mux and interrupt
    //--------------------------------------------------------------------------
    always_comb begin
        io_do = 8'd0;
        if (io_re) begin
            case (io_a)
                C_A_CAPL: io_do = r_cap[7:0];
                C_A_TMP:  io_do = r_tmp;
                C_A_CCR:  io_do = {r_cie, r_oie, 2'b00, r_esel, r_psel};
                C_A_CSR:  io_do = {r_capf, r_ovf, r_miss, 5'b00000};
                default:  io_do = 8'd0;
            endcase
        end
    end

    assign irq = (r_capf & r_cie) | (r_ovf & r_oie);

endmodule

`default_nettype wire

// File: tb/tb_avr_io_capture.sv
//==============================================================================
//  Module      : tb_avr_io_capture
//  Description : Self-checking bench for avr_io_capture. Directed stimulus
//                pushes expected read data / irq levels into a scoreboard
//                queue; an independent monitor pops and compares on the
//                falling clock edge whenever a read or irq sample is presented.
//
//  Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_avr_io_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_re;
    logic       io_we;
    logic [1:0] io_a;
    logic [7:0] io_do;
    logic [7:0] io_di;
    logic       cap_in;
    logic       irq;

    always #5 clk = ~clk;

    avr_io_capture dut (
        .clk    (clk),
        .rst    (rst),
        .io_re  (io_re),
        .io_we  (io_we),
        .io_a   (io_a),
        .io_do  (io_do),
        .io_di  (io_di),
        .cap_in (cap_in),
        .irq    (irq)
    );

    typedef struct {
        bit         is_irq;
        string      name;
        logic [7:0] lo;
        logic [7:0] hi;
    } exp_t;

    exp_t sb[$];
    logic irq_chk;
    int   n_checks = 0;
    int   n_pass   = 0;

    exp_t       mon_e;
    logic [7:0] mon_act;
    logic       mon_ok;

    //--------------------------------------------------------------------------
    // Monitor
    //--------------------------------------------------------------------------
    always @(negedge clk) begin
        if (io_re || irq_chk) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_sample: no expectation queued (io_do=0x%02h irq=%0b)",
                         io_do, irq);
            end else begin
                mon_e   = sb.pop_front();
                mon_act = mon_e.is_irq ? {7'd0, irq} : io_do;
                mon_ok  = (mon_act >= mon_e.lo) && (mon_act <= mon_e.hi);
                if (mon_ok === 1'b1) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got 0x%02h, want 0x%02h..0x%02h",
                             mon_e.name, mon_act, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers; every action starts 1 ns after a rising edge.
    //--------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        io_we = 1'b1;
        io_a  = a;
        io_di = d;
        step(1);
        io_we = 1'b0;
    endtask

    task automatic rd_rng(input logic [1:0] a, input logic [7:0] lo,
                          input logic [7:0] hi, input string nm);
        exp_t e;
        e.is_irq = 1'b0;
        e.name   = nm;
        e.lo     = lo;
        e.hi     = hi;
        sb.push_back(e);
        io_re = 1'b1;
        io_a  = a;
        step(1);
        io_re = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] v, input string nm);
        rd_rng(a, v, v, nm);
    endtask

    task automatic chk_irq(input logic v, input string nm);
        exp_t e;
        e.is_irq = 1'b1;
        e.name   = nm;
        e.lo     = {7'd0, v};
        e.hi     = {7'd0, v};
        sb.push_back(e);
        irq_chk = 1'b1;
        step(1);
        irq_chk = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        io_re   = 1'b0;
        io_we   = 1'b0;
        io_a    = 2'd0;
        io_di   = 8'd0;
        cap_in  = 1'b0;
        irq_chk = 1'b0;
        step(2);

        // Reset state
        chk_irq(1'b0, "rst_irq");
        rd(2'd0, 8'h00, "rst_capl");
        rst = 1'b0;
        rd(2'd1, 8'h00, "rst_tmp");
        rd(2'd2, 8'h00, "rst_ccr");
        rd(2'd3, 8'h00, "rst_csr");

        // Register access: CCR readback, CAPL write ignored, read beats write
        wr(2'd2, 8'h84);
        rd(2'd2, 8'h84, "ccr_readback");
        wr(2'd0, 8'hFF);
        rd(2'd0, 8'h00, "capl_write_ignored");
        io_we = 1'b1;
        io_di = 8'h00;
        rd(2'd2, 8'h84, "rdwr_read_value");
        io_we = 1'b0;
        rd(2'd2, 8'h84, "rdwr_write_ignored");
        wr(2'd1, 8'hA5);
        rd(2'd1, 8'hA5, "tmp_write");

        // Basic interval: rising edges 100 clk apart at /1 -> 99
        cap_in = 1'b1;
        step(3);
        wr(2'd3, 8'hE0);
        step(46);
        cap_in = 1'b0;
        step(50);
        cap_in = 1'b1;
        step(3);
        chk_irq(1'b1, "basic_irq");
        rd(2'd3, 8'h80, "basic_csr");
        rd(2'd0, 8'h63, "basic_capl");
        rd(2'd1, 8'h00, "basic_tmp");
        wr(2'd3, 8'h80);
        chk_irq(1'b0, "basic_irq_cleared");
        rd(2'd3, 8'h00, "basic_csr_cleared");

        // Prescale /16: rising edges 2000 clk apart -> 125 ticks (+0/-1)
        cap_in = 1'b0;
        step(5);
        wr(2'd3, 8'hE0);
        wr(2'd2, 8'h05);
        cap_in = 1'b1;
        step(1000);
        cap_in = 1'b0;
        step(1000);
        cap_in = 1'b1;
        step(3);
        rd_rng(2'd0, 8'h7C, 8'h7D, "presc_capl");
        rd(2'd1, 8'h00, "presc_tmp");

        // Atomic read: CAPL read in the capture cycle returns the old pair
        wr(2'd3, 8'hE0);
        cap_in = 1'b0;
        step(5);
        wr(2'd2, 8'h04);
        step(305);
        cap_in = 1'b1;
        step(2);
        rd_rng(2'd0, 8'h7C, 8'h7D, "atomic_old_lo");
        rd(2'd1, 8'h00, "atomic_old_hi");
        rd(2'd0, 8'h33, "atomic_new_lo");
        rd(2'd1, 8'h01, "atomic_new_hi");
        rd(2'd3, 8'h80, "atomic_csr");

        // Overflow at /1 with OIE, then a capture shortly after the wrap
        cap_in = 1'b0;
        step(5);
        wr(2'd3, 8'hE0);
        wr(2'd2, 8'h44);
        step(65534);
        rd(2'd3, 8'h00, "ovf_before_wrap");
        chk_irq(1'b0, "ovf_irq_before_wrap");
        chk_irq(1'b1, "ovf_irq");
        rd(2'd3, 8'h40, "ovf_csr");
        cap_in = 1'b1;
        step(3);
        rd(2'd0, 8'h04, "wrap_to_zero_capl");
        rd(2'd1, 8'h00, "wrap_to_zero_tmp");
        rd(2'd3, 8'hC0, "ovf_cap_csr");

        // Missed capture: both edges, 50 clk apart, never cleared
        wr(2'd3, 8'hE0);
        wr(2'd2, 8'h0C);
        cap_in = 1'b0;
        step(50);
        cap_in = 1'b1;
        step(50);
        cap_in = 1'b0;
        step(3);
        rd(2'd3, 8'hA0, "miss_csr");
        rd(2'd0, 8'h31, "miss_capl");
        rd(2'd1, 8'h00, "miss_tmp");
        chk_irq(1'b0, "miss_irq_masked");
        cap_in = 1'b1;
        step(2);
        wr(2'd3, 8'hE0);
        rd(2'd3, 8'h80, "clear_vs_capture_csr");
        rd(2'd0, 8'h06, "clear_vs_capture_capl");

        // Fall-only mode with a one-clock high pulse
        wr(2'd2, 8'h00);
        cap_in = 1'b0;
        step(5);
        wr(2'd3, 8'hE0);
        wr(2'd2, 8'h08);
        cap_in = 1'b1;
        step(1);
        cap_in = 1'b0;
        step(2);
        rd(2'd3, 8'h00, "fall_no_cap_on_rise");
        rd(2'd3, 8'h80, "fall_cap_csr");
        rd(2'd0, 8'h03, "fall_cap_capl");

        // Sub-cycle glitch never sampled by the synchronizer
        wr(2'd3, 8'hE0);
        cap_in = 1'b1;
        #3;
        cap_in = 1'b0;
        step(5);
        rd(2'd3, 8'h00, "glitch_ignored");

        // Asynchronous reset mid-measurement
        wr(2'd2, 8'h84);
        cap_in = 1'b1;
        step(3);
        chk_irq(1'b1, "pre_rst_irq");
        rst = 1'b1;
        chk_irq(1'b0, "rst_async_irq");
        rst = 1'b0;
        rd(2'd3, 8'h00, "post_rst_csr");
        rd(2'd2, 8'h00, "post_rst_ccr");
        rd(2'd0, 8'h00, "post_rst_capl");
        rd(2'd1, 8'h00, "post_rst_tmp");
        cap_in = 1'b0;
        step(3);
        cap_in = 1'b1;
        step(5);
        rd(2'd3, 8'h00, "no_cap_after_rst");

        step(1);
        @(negedge clk);
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: got no sample, want 0x%02h..0x%02h",
                     mon_e.name, mon_e.lo, mon_e.hi);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
